// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with a bounded hold time per grant.
// Grant, index and valid are all registered and change one edge after the request is sampled.
module rr_arbiter16 #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  idx,
  output logic        valid
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);

  state_t      state_r;
  logic [3:0]  ptr_r;
  logic [3:0]  hcnt_r;
  logic [15:0] gnt_r;
  logic [3:0]  idx_r;
  logic        valid_r;

  logic [3:0]  search_ptr_s;
  logic [3:0]  probe_s;
  logic [3:0]  cand_s;
  logic        found_s;
  logic        release_s;

  // Release detection and circular search; when releasing, the search starts just past the current holder.
  always_comb begin
    search_ptr_s = 4'd0;
    probe_s      = 4'd0;
    cand_s       = 4'd0;
    found_s      = 1'b0;
    release_s    = 1'b0;
    if (state_r == BUSY) begin
      search_ptr_s = idx_r + 4'd1;
      release_s    = (!req[idx_r]) || (hcnt_r == HOLD_MAX_C) || (!en);
    end else begin
      search_ptr_s = ptr_r;
      release_s    = 1'b0;
    end
    // Scan from the far end so the offset nearest the pointer wins.
    for (int k = 15; k >= 0; k--) begin
      probe_s = search_ptr_s + 4'(k);
      if (req[probe_s]) begin
        found_s = 1'b1;
        cand_s  = probe_s;
      end else begin
        found_s = found_s;
        cand_s  = cand_s;
      end
    end
  end

  // Arbitration state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 4'd0;
      hcnt_r  <= 4'd0;
      gnt_r   <= 16'h0000;
      idx_r   <= 4'd0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en && found_s) begin
            state_r <= BUSY;
            idx_r   <= cand_s;
            gnt_r   <= 16'd1 << cand_s;
            valid_r <= 1'b1;
            hcnt_r  <= 4'd1;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (release_s) begin
            ptr_r <= idx_r + 4'd1;
            if (en && found_s) begin
              state_r <= BUSY;
              idx_r   <= cand_s;
              gnt_r   <= 16'd1 << cand_s;
              valid_r <= 1'b1;
              hcnt_r  <= 4'd1;
            end else begin
              state_r <= IDLE;
              gnt_r   <= 16'h0000;
              valid_r <= 1'b0;
              hcnt_r  <= 4'd0;
            end
          end else begin
            hcnt_r <= hcnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          ptr_r   <= 4'd0;
          hcnt_r  <= 4'd0;
          gnt_r   <= 16'h0000;
          idx_r   <= 4'd0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = gnt_r;
  assign idx   = idx_r;
  assign valid = valid_r;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed testbench for rr_arbiter16 (HOLD_MAX = 8); each scenario task checks {valid, idx, gnt}.
module tb_rr_arbiter16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  idx;
  logic        valid;

  int n_checks;
  int n_fail;

  rr_arbiter16 #(.HOLD_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .gnt   (gnt),
    .idx   (idx),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 16'h0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 16'hFFFF;
    tick();
    tick();
    n_checks++;
    if ({valid, idx, gnt} !== {1'b0, 4'd0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset: got valid=%b idx=%0d gnt=%h, want 0/0/0000", valid, idx, gnt);
    end
    rst_n = 1'b1;
  endtask

  // A lone requester is re-granted at expiry with no idle gap.
  task automatic test_single();
    do_reset();
    req = 16'h0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if ({valid, idx, gnt} !== {1'b1, 4'd0, 16'h0001}) begin
        n_fail++;
        $display("FAIL single c=%0d: got valid=%b idx=%0d gnt=%h, want 1/0/0001", c, valid, idx, gnt);
      end
    end
  endtask

  task automatic test_rotate();
    logic [3:0] e;
    do_reset();
    req = 16'hFFFF;
    for (int g = 0; g < 17; g++) begin
      e = 4'(g);
      for (int c = 0; c < 8; c++) begin
        tick();
        n_checks++;
        if ({valid, idx, gnt} !== {1'b1, e, 16'd1 << e}) begin
          n_fail++;
          $display("FAIL rotate g=%0d c=%0d: got valid=%b idx=%0d gnt=%h, want idx=%0d", g, c, valid, idx, gnt, e);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] e;
    do_reset();
    req = 16'h4000;
    tick();
    n_checks++;
    if ({valid, idx} !== {1'b1, 4'd14}) begin
      n_fail++;
      $display("FAIL wrap_pre: got valid=%b idx=%0d, want 1/14", valid, idx);
    end
    req = 16'h8001;
    for (int p = 0; p < 3; p++) begin
      e = (p == 1) ? 4'd0 : 4'd15;
      for (int c = 0; c < ((p == 2) ? 1 : 8); c++) begin
        tick();
        n_checks++;
        if ({valid, idx, gnt} !== {1'b1, e, 16'd1 << e}) begin
          n_fail++;
          $display("FAIL wrap p=%0d c=%0d: got valid=%b idx=%0d gnt=%h, want idx=%0d", p, c, valid, idx, gnt, e);
        end
      end
    end
  endtask

  // Holder drops early; the new holder starts a fresh full-length hold.
  task automatic test_drop();
    logic [3:0] e;
    do_reset();
    req = 16'h0208;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({valid, idx, gnt} !== {1'b1, 4'd3, 16'h0008}) begin
        n_fail++;
        $display("FAIL drop_hold3 c=%0d: got valid=%b idx=%0d gnt=%h, want 1/3/0008", c, valid, idx, gnt);
      end
    end
    req = 16'h0200;
    tick();
    n_checks++;
    if ({valid, idx, gnt} !== {1'b1, 4'd9, 16'h0200}) begin
      n_fail++;
      $display("FAIL drop_switch: got valid=%b idx=%0d gnt=%h, want 1/9/0200", valid, idx, gnt);
    end
    req = 16'h0208;
    for (int c = 0; c < 8; c++) begin
      tick();
      e = (c < 7) ? 4'd9 : 4'd3;
      n_checks++;
      if ({valid, idx, gnt} !== {1'b1, e, 16'd1 << e}) begin
        n_fail++;
        $display("FAIL drop_hcnt c=%0d: got valid=%b idx=%0d gnt=%h, want idx=%0d", c, valid, idx, gnt, e);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    req = 16'hFFFF;
    tick();
    tick();
    tick();
    n_checks++;
    if ({valid, idx} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL en_pre: got valid=%b idx=%0d, want 1/0", valid, idx);
    end
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({valid, gnt} !== {1'b0, 16'h0000}) begin
        n_fail++;
        $display("FAIL en_off c=%0d: got valid=%b gnt=%h, want 0/0000", c, valid, gnt);
      end
    end
    en = 1'b1;
    tick();
    n_checks++;
    if ({valid, idx, gnt} !== {1'b1, 4'd1, 16'h0002}) begin
      n_fail++;
      $display("FAIL en_on: got valid=%b idx=%0d gnt=%h, want 1/1/0002", valid, idx, gnt);
    end
    req = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({valid, gnt} !== {1'b0, 16'h0000}) begin
        n_fail++;
        $display("FAIL empty c=%0d: got valid=%b gnt=%h, want 0/0000", c, valid, gnt);
      end
    end
    req = 16'h0003;
    tick();
    n_checks++;
    if ({valid, idx, gnt} !== {1'b1, 4'd0, 16'h0001}) begin
      n_fail++;
      $display("FAIL empty_regrant: got valid=%b idx=%0d gnt=%h, want 1/0/0001", valid, idx, gnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 16'h0020;
    tick();
    tick();
    n_checks++;
    if ({valid, idx, gnt} !== {1'b1, 4'd5, 16'h0020}) begin
      n_fail++;
      $display("FAIL rmid_pre: got valid=%b idx=%0d gnt=%h, want 1/5/0020", valid, idx, gnt);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({valid, idx, gnt} !== {1'b0, 4'd0, 16'h0000}) begin
      n_fail++;
      $display("FAIL rmid_rst: got valid=%b idx=%0d gnt=%h, want 0/0/0000", valid, idx, gnt);
    end
    rst_n = 1'b1;
    req   = 16'hFFFF;
    tick();
    n_checks++;
    if ({valid, idx, gnt} !== {1'b1, 4'd0, 16'h0001}) begin
      n_fail++;
      $display("FAIL rmid_post: got valid=%b idx=%0d gnt=%h, want 1/0/0001", valid, idx, gnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    req      = 16'h0000;
    test_reset();
    test_single();
    test_rotate();
    test_wrap();
    test_drop();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 The block SHALL have one parameter: HOLD_MAX, default 8, the maximum number of consecutive cycles one grant is held (legal range 1..15).
REQ-002 CLK  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 RST_N  input  1  reset, synchronous and active-low.
REQ-004 EN  input  1  arbiter enable; low means no new grants are issued and any current grant is revoked.
REQ-005 REQ  input  16  request vector; bit i high means requester i wants the shared 16-way resource.
REQ-006 GNT  output  16  registered one-hot grant, matching the 4-to-16 decode of IDX while VALID=1, else all zero.
REQ-007 IDX  output  4  registered index of the granted requester; it drives the select input of the downstream 4-to-16 decoder.
REQ-008 VALID  output  1  registered; high while a grant is active, and it drives the decoder enable.

Function
REQ-009 The block SHALL implement two states: IDLE (no grant) and BUSY (grant active).
REQ-010 The block SHALL hold a 4-bit rotating pointer PTR and a 4-bit hold counter HCNT.
REQ-011 Search rule: candidate = first i with REQ[i]=1, scanning circularly PTR, PTR+1, ..., 15, 0, ..., PTR-1 (mod 16).
REQ-012 IDLE with EN=1 and REQ!=0 at an edge -> BUSY; IDX=candidate; GNT=one-hot(candidate); VALID=1; HCNT=1.
REQ-013 Grant latency SHALL be exactly one edge: REQ sampled at edge N gives GNT visible after edge N.
REQ-014 IDLE with EN=0 or REQ=0 -> stay IDLE; outputs unchanged (zero, IDX held).
REQ-015 BUSY release condition: REQ[IDX]=0, or HCNT=HOLD_MAX, or EN=0, sampled at the edge.
REQ-016 BUSY with no release condition -> stay; HCNT increments; GNT/IDX unchanged, so a grant lasts at most HOLD_MAX cycles.
REQ-017 On release, PTR SHALL become IDX+1 mod 16 (15 wraps to 0), so the released requester gets lowest priority.
REQ-018 Release with EN=1: the search uses the new PTR and the current REQ; if any candidate exists, the new grant SHALL be issued at the same edge (back-to-back, no idle gap) with HCNT=1; otherwise -> IDLE, GNT=0, VALID=0.
REQ-019 If the expiring requester is the only one still requesting, the block SHALL re-grant it at the same edge with HCNT=1.
REQ-020 Release with EN=0 -> IDLE, GNT=0, VALID=0 at that edge; no grant is issued while EN=0.
REQ-021 Invariants: GNT is zero or exactly one-hot; GNT!=0 iff VALID=1; GNT[IDX]=1 whenever VALID=1.
REQ-022 REQ changes on bits other than IDX SHALL NOT affect an active grant.

Reset
REQ-023 When RST_N=0 at an edge, the block SHALL set state=IDLE, PTR=0, HCNT=0, GNT=16'h0000, IDX=4'd0, VALID=0, regardless of state or EN.
REQ-024 Reset SHALL take priority over every other condition and revoke a grant mid-hold; the first grant after reset SHALL use PTR=0.

Verification
REQ-025 Reset, EN=1, REQ=16'h0001 held -> after 1 edge GNT=16'h0001, IDX=0, VALID=1 for 8 cycles; then re-granted with no gap (HOLD_MAX=8).
REQ-026 REQ=16'hFFFF constant, HOLD_MAX=8 -> IDX sequence 0,1,...,15,0, each held exactly 8 cycles, no idle cycles.
REQ-027 REQ=16'h8001, PTR=15 after granting 14 -> grant IDX=15, then on release IDX=0 (wrap-around), then 15.
REQ-028 Requester 3 granted, REQ[3] drops after 3 cycles while REQ[9]=1 -> at that edge GNT=16'h0200, IDX=9, HCNT=1.
REQ-029 EN=0 mid-grant with REQ=16'hFFFF -> next edge GNT=0, VALID=0; stays 0 while EN=0; EN=1 -> grant to IDX=PTR (released IDX+1).
REQ-030 RST_N=0 for one cycle during grant to IDX=5 -> GNT=0, VALID=0, IDX=0; RST_N=1 with REQ=16'hFFFF -> next grant IDX=0.
